// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial subtractor computing a - b - borrow_in, one bit per
//            clock, LSB first, using a single 1-bit subtract cell. Handshake
//            is start / busy / done. All outputs are registered.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   system clock, rising-edge active
//   rst         in   synchronous active-high reset
//   start       in   operation request, sampled only while idle
//   a           in   [NUM_BITS] minuend, captured on accepted start
//   b           in   [NUM_BITS] subtrahend, captured on accepted start
//   borrow_in   in   initial borrow, captured on accepted start
//   busy        out  high from the cycle after acceptance through done
//   done        out  one-cycle pulse when the result is valid
//   difference  out  [NUM_BITS] (a - b - borrow_in) mod 2^NUM_BITS
//   borrow_out  out  final borrow (unsigned underflow)
//   overflow    out  two's-complement overflow of the subtraction
// ============================================================================
module serial_subtractor #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] difference,
  output logic                borrow_out,
  output logic                overflow
);

  localparam int                CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_BITS - 1);
  localparam int                MSB   = NUM_BITS - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [NUM_BITS-1:0] a_sh;
  logic [NUM_BITS-1:0] b_sh;
  logic [NUM_BITS-1:0] r_sh;
  logic                brw;
  logic                a_msb;   // sign bits of the captured operands,
  logic                b_msb;   // kept because a_sh/b_sh are shifted away
  logic [CNT_W-1:0]    count;

  // Single 1-bit full-subtractor cell.
  logic bit_diff;
  logic bit_borrow;

  assign bit_diff   = a_sh[0] ^ b_sh[0] ^ brw;
  assign bit_borrow = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      brw        <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      difference <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // busy stays high through the done cycle (first IDLE cycle), then
          // drops unless a new operation is accepted right away.
          busy <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= borrow_in;
            a_msb <= a[MSB];
            b_msb <= b[MSB];
            count <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          brw   <= bit_borrow;
          r_sh  <= {bit_diff, r_sh[NUM_BITS-1:1]};
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          done       <= 1'b1;
          difference <= r_sh;
          borrow_out <= brw;
          // Signed overflow: operand signs differ and the result sign
          // differs from the minuend sign.
          overflow   <= (a_msb ^ b_msb) & (r_sh[MSB] ^ a_msb);
          state      <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor (NUM_BITS = 4).
//            Expected results are queued when an operation is started and
//            compared when the design pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [N-1:0] difference;
  logic         borrow_out;
  logic         overflow;

  serial_subtractor #(.NUM_BITS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t sb_q[$];
  exp_t hold_exp;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                 input logic c);
    exp_t e;
    int   diff_i;
    diff_i = int'(av) - int'(bv) - int'(c);
    e.d  = N'(diff_i + (1 << N));
    e.bo = (int'(av) < int'(bv) + int'(c));
    e.ov = (av[N-1] != bv[N-1]) && (e.d[N-1] != av[N-1]);
    return e;
  endfunction

  // Done monitor: pops on every done, otherwise outputs must hold.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("difference", 32'(difference), 32'(e.d));
          check_eq("borrow_out", 32'(borrow_out), 32'(e.bo));
          check_eq("overflow",   32'(overflow),   32'(e.ov));
          hold_exp = e;
        end
      end else begin
        check_eq("hold_outputs", 32'({difference, borrow_out, overflow}),
                 32'({hold_exp.d, hold_exp.bo, hold_exp.ov}));
      end
    end
  end

  // Waits for done after the acceptance edge; expects it after edge N+1.
  task automatic wait_done(input string tag, input bit scramble);
    int cyc;
    cyc = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      if (scramble) begin
        a         = N'($urandom);
        b         = N'($urandom);
        borrow_in = 1'($urandom);
      end
      if (cyc > N + 4) break;
    end
    check_eq({tag, "_latency"}, 32'(cyc), 32'(N + 1));
    check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd1);
  endtask

  // Called at #1 after a rising edge with the design idle.
  task automatic drive_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic c);
    a         = av;
    b         = bv;
    borrow_in = c;
    start     = 1'b1;
    sb_q.push_back(model(av, bv, c));
    @(posedge clk); #1;
    start     = 1'b0;
    a         = N'($urandom);
    b         = N'($urandom);
    borrow_in = 1'($urandom);
    check_eq("busy_after_start", 32'(busy), 32'd1);
    check_eq("done_low_in_shift", 32'(done), 32'd0);
    wait_done("op", 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    hold_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_outputs", 32'({difference, borrow_out, overflow}), 32'd0);
    mon_en = 1'b1;

    // Directed vectors
    drive_op(4'd9, 4'd3, 1'b0);
    drive_op(4'd3, 4'd9, 1'b0);
    drive_op(4'd0, 4'd0, 1'b1);
    drive_op(4'd8, 4'd1, 1'b0);

    // Start held high with changing operands: only the first set is used,
    // the next acceptance happens in the done cycle's following edge.
    a = 4'd7; b = 4'd2; borrow_in = 1'b0; start = 1'b1;
    sb_q.push_back(model(4'd7, 4'd2, 1'b0));
    @(posedge clk); #1;
    wait_done("held1", 1'b1);
    a = 4'hC; b = 4'h5; borrow_in = 1'b1;
    sb_q.push_back(model(4'hC, 4'h5, 1'b1));
    @(posedge clk); #1;
    check_eq("held_reaccept_busy", 32'(busy), 32'd1);
    wait_done("held2", 1'b1);
    start = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_busy_low", 32'(busy), 32'd0);

    // Reset on the second SHIFT cycle discards the operation.
    a = 4'd5; b = 4'd2; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hold_exp = '0;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_outputs", 32'({difference, borrow_out, overflow}), 32'd0);
    repeat (N + 4) @(posedge clk);
    #1;
    drive_op(4'd5, 4'd2, 1'b0);

    // Exhaustive sweep
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          drive_op(N'(ai), N'(bi), 1'(ci));

    repeat (3) @(posedge clk);
    #1;
    check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
